regfile_wb_arbiter: RTL

- Writeback arbiter sitting between REQ_COUNT execution-unit result buses and the WRITE_PORTS write ports of the physical register file.
- Each cycle it selects up to WRITE_PORTS pending results round-robin, with valid/ready handshakes on the requester side.
- Selected results are driven onto registered write ports one cycle later.
- Two grants to the same physical address are never issued in one cycle.

---
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin writeback arbiter, REQ_COUNT result buses onto WRITE_PORTS register file write ports.
// Latency: grant is combinational in the request cycle; write enable appears exactly 1 cycle after the handshake.
// Backpressure: req_ready low holds a requester; same-address and over-subscribed requests are deferred to later cycles.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int STATE_WIDTH = 4,
    parameter int PHYS_COUNT  = 64,
    parameter int ADDR_WIDTH  = $clog2(PHYS_COUNT),
    parameter int REQ_COUNT   = 4,
    parameter int WRITE_PORTS = 2,
    localparam int PTR_WIDTH  = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
    input  logic                                     clk,
    input  logic                                     async_rst_n,
    input  logic                                     clk_en,
    input  logic [REQ_COUNT-1:0]                     req_valid,
    input  logic [REQ_COUNT-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [REQ_COUNT-1:0][DATA_WIDTH-1:0]     req_data,
    input  logic [REQ_COUNT-1:0][STATE_WIDTH-1:0]    req_state,
    output logic [REQ_COUNT-1:0]                     req_ready,
    output logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]   wr_addr,
    output logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]   wr_data,
    output logic [WRITE_PORTS-1:0][STATE_WIDTH-1:0]  wr_state,
    output logic [WRITE_PORTS-1:0]                   wr_data_en,
    output logic [WRITE_PORTS-1:0]                   wr_state_en,
    output logic [PTR_WIDTH-1:0]                     rr_ptr
);

    // Arbitration results for the current cycle.
    logic [REQ_COUNT-1:0]                   grant;
    logic [WRITE_PORTS-1:0]                 port_vld;
    logic [WRITE_PORTS-1:0][PTR_WIDTH-1:0]  port_sel;
    logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] port_addr;
    logic [PTR_WIDTH-1:0]                   ptr_nxt;

    // Scan temporaries.
    logic [PTR_WIDTH:0]                     idx_sum;
    logic [PTR_WIDTH-1:0]                   idx;
    logic                                   conflict;
    logic                                   placed;

    // Round-robin scan from rr_ptr: each valid requester takes the lowest free
    // port unless its address is already claimed this cycle or ports are full.
    always_comb begin
        grant     = '0;
        port_vld  = '0;
        port_sel  = '0;
        port_addr = '0;
        ptr_nxt   = rr_ptr;
        idx_sum   = '0;
        idx       = '0;
        conflict  = 1'b0;
        placed    = 1'b0;
        for (int j = 0; j < REQ_COUNT; j++) begin
            idx_sum = {1'b0, rr_ptr} + (PTR_WIDTH+1)'(j);
            if (idx_sum >= (PTR_WIDTH+1)'(REQ_COUNT)) begin
                idx_sum = idx_sum - (PTR_WIDTH+1)'(REQ_COUNT);
            end
            idx = idx_sum[PTR_WIDTH-1:0];

            conflict = 1'b0;
            for (int k = 0; k < WRITE_PORTS; k++) begin
                if (port_vld[k] && (port_addr[k] == req_addr[idx])) begin
                    conflict = 1'b1;
                end
            end

            placed = 1'b0;
            if (req_valid[idx] && !conflict) begin
                for (int k = 0; k < WRITE_PORTS; k++) begin
                    if (!placed && !port_vld[k]) begin
                        port_vld[k]  = 1'b1;
                        port_sel[k]  = idx;
                        port_addr[k] = req_addr[idx];
                        grant[idx]   = 1'b1;
                        placed       = 1'b1;
                        // Next scan starts just after the most recent grant.
                        if (idx == PTR_WIDTH'(REQ_COUNT - 1)) begin
                            ptr_nxt = '0;
                        end else begin
                            ptr_nxt = idx + PTR_WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

    // Grants are only visible while the block is enabled and out of reset,
    // so no handshake can complete in a cycle whose write would be lost.
    assign req_ready = grant & {REQ_COUNT{clk_en & async_rst_n}};

    // Register the selected results onto the write ports and advance the pointer;
    // ungranted ports keep their last payload with the enable dropped.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rr_ptr     <= '0;
            wr_data_en <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_state   <= '0;
        end else if (clk_en) begin
            rr_ptr     <= ptr_nxt;
            wr_data_en <= port_vld;
            for (int k = 0; k < WRITE_PORTS; k++) begin
                if (port_vld[k]) begin
                    wr_addr[k]  <= req_addr[port_sel[k]];
                    wr_data[k]  <= req_data[port_sel[k]];
                    wr_state[k] <= req_state[port_sel[k]];
                end
            end
        end
    end

    // Data and state always land together in the register file.
    assign wr_state_en = wr_data_en;

endmodule
